// File: rtl/br_ctrl_if.sv
// rtl/br_ctrl_if.sv - handshake/bus bundle between ID, EX branch controller and IF
//   slave  : controller side (br_ctrl)
//   master : environment side (ID/IF/pipeline control)
//   BR_STAT_EN adds the stat_* counter outputs.
interface br_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [31:0] in_pc;
    logic [31:0] in_rj_val;
    logic [31:0] in_rd_val;
    logic [31:0] in_offs;
    logic [4:0]  in_rd;
    logic        flush;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        done;
    logic        done_taken;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        busy;
`ifdef BR_STAT_EN
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_taken_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    modport slave (
        input  in_valid, in_op, in_pc, in_rj_val, in_rd_val, in_offs, in_rd,
        input  flush, redir_ready,
        output in_ready, redir_valid, redir_pc, done, done_taken,
        output wb_valid, wb_rd, wb_data, illegal, busy
`ifdef BR_STAT_EN
        , output stat_br_cnt, stat_taken_cnt, stat_stall_cnt
`endif
    );

    modport master (
        output in_valid, in_op, in_pc, in_rj_val, in_rd_val, in_offs, in_rd,
        output flush, redir_ready,
        input  in_ready, redir_valid, redir_pc, done, done_taken,
        input  wb_valid, wb_rd, wb_data, illegal, busy
`ifdef BR_STAT_EN
        , input stat_br_cnt, stat_taken_cnt, stat_stall_cnt
`endif
    );
endinterface

// File: rtl/br_ctrl.sv
// rtl/br_ctrl.sv - EX-stage branch/jump resolution controller with IF redirect handshake
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : br_ctrl_if.slave (ID operation in, IF redirect out, link write-back,
//           completion/illegal pulses, busy)
//   Optional macro BR_STAT_EN: done/taken/stall 32-bit counters on bus.stat_*.
module br_ctrl (
    input  logic      clk,
    input  logic      reset,
    br_ctrl_if.slave  bus
);
    localparam logic [7:0] OP_JIRL    = 8'h13;
    localparam logic [7:0] OP_B       = 8'h14;
    localparam logic [7:0] OP_BL      = 8'h15;
    localparam logic [7:0] OP_BEQ     = 8'h16;
    localparam logic [7:0] OP_BNE     = 8'h17;
    localparam logic [7:0] OP_BLT     = 8'h18;
    localparam logic [7:0] OP_BGE     = 8'h19;
    localparam logic [7:0] OP_BLTU    = 8'h1A;
    localparam logic [7:0] OP_BGEU    = 8'h1B;
    localparam logic [7:0] OP_INVALID = 8'hFF;

    typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_REDIRECT} state_t;

    state_t      r_state;
    logic        r_taken;
    logic        r_illegal;
    logic        r_link;
    logic [31:0] r_target;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_taken;
    logic        w_illegal;
    logic        w_link;
    logic [31:0] w_target;
    logic [4:0]  w_wb_rd;
    logic        w_accept;
    logic        w_done;

    // Condition and target are resolved from the ID operands at capture time so
    // that every RESOLVE/REDIRECT output comes straight from flops.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_link    = 1'b0;
        w_target  = bus.in_pc + bus.in_offs;
        w_wb_rd   = 5'd1;
        case (bus.in_op)
            OP_JIRL: begin
                w_taken  = 1'b1;
                w_link   = 1'b1;
                w_target = bus.in_rj_val + bus.in_offs;
                w_wb_rd  = bus.in_rd;
            end
            OP_B:    w_taken = 1'b1;
            OP_BL: begin
                w_taken = 1'b1;
                w_link  = 1'b1;
            end
            OP_BEQ:  w_taken = (bus.in_rj_val == bus.in_rd_val);
            OP_BNE:  w_taken = (bus.in_rj_val != bus.in_rd_val);
            OP_BLT:  w_taken = ($signed(bus.in_rj_val) <  $signed(bus.in_rd_val));
            OP_BGE:  w_taken = ($signed(bus.in_rj_val) >= $signed(bus.in_rd_val));
            OP_BLTU: w_taken = (bus.in_rj_val <  bus.in_rd_val);
            OP_BGEU: w_taken = (bus.in_rj_val >= bus.in_rd_val);
            default: w_illegal = 1'b1;  // includes OP_INVALID
        endcase
    end

    assign w_accept = bus.in_valid && bus.in_ready;

    // Flush masks every pulse-type output in its own cycle.
    assign w_done = !bus.flush &&
                    (((r_state == S_RESOLVE) && (!r_taken || bus.redir_ready)) ||
                     ((r_state == S_REDIRECT) && bus.redir_ready));

    assign bus.in_ready    = (r_state == S_IDLE) && !bus.flush;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.redir_valid = !bus.flush &&
                             (((r_state == S_RESOLVE) && r_taken) || (r_state == S_REDIRECT));
    assign bus.redir_pc    = r_target;
    assign bus.done        = w_done;
    assign bus.done_taken  = (r_state != S_IDLE) && r_taken;
    assign bus.wb_valid    = !bus.flush && (r_state == S_RESOLVE) && r_link;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.illegal     = !bus.flush && (r_state == S_RESOLVE) && r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_link    <= 1'b0;
            r_target  <= 32'd0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_RESOLVE;
                        r_taken   <= w_taken;
                        r_illegal <= w_illegal;
                        r_link    <= w_link && !w_illegal;
                        r_target  <= w_target;
                        r_wb_rd   <= w_wb_rd;
                        r_wb_data <= bus.in_pc + 32'd4;
                    end
                end
                S_RESOLVE: begin
                    if (r_taken && !bus.redir_ready)
                        r_state <= S_REDIRECT;
                    else
                        r_state <= S_IDLE;
                end
                S_REDIRECT: begin
                    if (bus.redir_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BR_STAT_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_br    <= 32'd0;
            r_stat_taken <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_done)
                r_stat_br <= r_stat_br + 32'd1;
            if (w_done && r_taken)
                r_stat_taken <= r_stat_taken + 32'd1;
            if (!bus.flush && (r_state == S_REDIRECT) && !bus.redir_ready)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign bus.stat_br_cnt    = r_stat_br;
    assign bus.stat_taken_cnt = r_stat_taken;
    assign bus.stat_stall_cnt = r_stat_stall;
`endif
endmodule

// File: tb/tb_br_ctrl.sv
// tb/tb_br_ctrl.sv - directed self-checking bench for br_ctrl
module tb_br_ctrl;
    localparam logic [7:0] OP_JIRL    = 8'h13;
    localparam logic [7:0] OP_BL      = 8'h15;
    localparam logic [7:0] OP_BEQ     = 8'h16;
    localparam logic [7:0] OP_BNE     = 8'h17;
    localparam logic [7:0] OP_BLT     = 8'h18;
    localparam logic [7:0] OP_BGE     = 8'h19;
    localparam logic [7:0] OP_BLTU    = 8'h1A;
    localparam logic [7:0] OP_INVALID = 8'hFF;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    br_ctrl_if bus();
    br_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] rj,
                         input logic [31:0] rd, input logic [31:0] offs, input logic [4:0] rd_idx);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_pc     = pc;
        bus.in_rj_val = rj;
        bus.in_rd_val = rd;
        bus.in_offs   = offs;
        bus.in_rd     = rd_idx;
        #1;
        check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.in_valid = 0; bus.in_op = 0; bus.in_pc = 0; bus.in_rj_val = 0;
        bus.in_rd_val = 0; bus.in_offs = 0; bus.in_rd = 0; bus.flush = 0;
        bus.redir_ready = 0;
        #3;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        check("rst_redir_pc", bus.redir_pc, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // BEQ taken, IF ready immediately
        bus.redir_ready = 1'b1;
        offer(OP_BEQ, 32'h1C000000, 32'd5, 32'd5, 32'h40, 5'd0);
        check("beq_redir_valid", {31'd0, bus.redir_valid}, 32'd1);
        check("beq_redir_pc", bus.redir_pc, 32'h1C000040);
        check("beq_done", {31'd0, bus.done}, 32'd1);
        check("beq_done_taken", {31'd0, bus.done_taken}, 32'd1);
        check("beq_in_ready_t1", {31'd0, bus.in_ready}, 32'd0);
        check("beq_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        tick(); #1;
        check("beq_in_ready_t2", {31'd0, bus.in_ready}, 32'd1);
        check("beq_done_t2", {31'd0, bus.done}, 32'd0);

        // Signed vs unsigned compare of -1 and 1
        offer(OP_BLT, 32'h00000100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0);
        check("blt_redir_valid", {31'd0, bus.redir_valid}, 32'd1);
        check("blt_redir_pc", bus.redir_pc, 32'h00000120);
        check("blt_done_taken", {31'd0, bus.done_taken}, 32'd1);
        tick();
        offer(OP_BLTU, 32'h00000100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0);
        check("bltu_done", {31'd0, bus.done}, 32'd1);
        check("bltu_done_taken", {31'd0, bus.done_taken}, 32'd0);
        check("bltu_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        tick();

        // BNE with equal operands: not taken; BGE with equal operands: taken
        offer(OP_BNE, 32'h00000200, 32'd9, 32'd9, 32'h10, 5'd0);
        check("bne_done", {31'd0, bus.done}, 32'd1);
        check("bne_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        tick();
        offer(OP_BGE, 32'h00000200, 32'h80000000, 32'h80000000, 32'hFFFFFFF0, 5'd0);
        check("bge_redir_pc", bus.redir_pc, 32'h000001F0);
        check("bge_done_taken", {31'd0, bus.done_taken}, 32'd1);
        tick();

        // JIRL with IF stalled in RESOLVE and three REDIRECT cycles
        bus.redir_ready = 1'b0;
        offer(OP_JIRL, 32'h1C000100, 32'h1C001000, 32'd0, 32'hFFFFFFFC, 5'd7);
        check("jirl_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("jirl_wb_rd", {27'd0, bus.wb_rd}, 32'd7);
        check("jirl_wb_data", bus.wb_data, 32'h1C000104);
        check("jirl_redir_pc", bus.redir_pc, 32'h1C000FFC);
        check("jirl_done_resolve", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("jirl_stall_valid", {31'd0, bus.redir_valid}, 32'd1);
            check("jirl_stall_pc", bus.redir_pc, 32'h1C000FFC);
            check("jirl_stall_done", {31'd0, bus.done}, 32'd0);
            check("jirl_stall_wb", {31'd0, bus.wb_valid}, 32'd0);
        end
        tick();
        bus.redir_ready = 1'b1;
        #1;
        check("jirl_hs_done", {31'd0, bus.done}, 32'd1);
        check("jirl_hs_taken", {31'd0, bus.done_taken}, 32'd1);
        check("jirl_hs_pc", bus.redir_pc, 32'h1C000FFC);
`ifdef BR_STAT_EN
        check("stat_stall", bus.stat_stall_cnt, 32'd3);
        check("stat_br", bus.stat_br_cnt, 32'd5);
`endif
        tick(); #1;
        check("jirl_idle", {31'd0, bus.busy}, 32'd0);

        // Flush while a BL redirect is pending
        bus.redir_ready = 1'b0;
        offer(OP_BL, 32'h00002000, 32'd0, 32'd0, 32'h100, 5'd0);
        check("bl_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("bl_wb_rd", {27'd0, bus.wb_rd}, 32'd1);
        check("bl_wb_data", bus.wb_data, 32'h00002004);
        tick();
        bus.flush = 1'b1;
        #1;
        check("fl_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        check("fl_done", {31'd0, bus.done}, 32'd0);
        check("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("fl_busy_after", {31'd0, bus.busy}, 32'd0);
        check("fl_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        tick(); #1;
        check("fl_no_redirect", {31'd0, bus.redir_valid}, 32'd0);

        // Invalid and unrecognised op codes
        offer(OP_INVALID, 32'h3000, 32'd1, 32'd1, 32'h8, 5'd3);
        check("inv_illegal", {31'd0, bus.illegal}, 32'd1);
        check("inv_done", {31'd0, bus.done}, 32'd1);
        check("inv_done_taken", {31'd0, bus.done_taken}, 32'd0);
        check("inv_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("inv_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        tick();
        offer(8'h55, 32'h3000, 32'd1, 32'd1, 32'h8, 5'd3);
        check("unk_illegal", {31'd0, bus.illegal}, 32'd1);
        tick(); #1;
        check("unk_illegal_clear", {31'd0, bus.illegal}, 32'd0);

        // Asynchronous reset while in RESOLVE
        bus.redir_ready = 1'b1;
        offer(OP_BEQ, 32'h1C000000, 32'd5, 32'd5, 32'h40, 5'd0);
        check("ar_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar_busy", {31'd0, bus.busy}, 32'd0);
        check("ar_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
        check("ar_done", {31'd0, bus.done}, 32'd0);
        check("ar_redir_pc", bus.redir_pc, 32'd0);
        check("ar_wb_data", bus.wb_data, 32'd0);
        check("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #2;
        reset = 1'b0;
        tick(); #1;
        check("ar_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("ar_busy_after", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
